// File: rtl/rf_write_port_sched_if.sv
// rf_write_port_sched_if: requester bundle and RAM write-port bundle of the scheduler
interface rf_write_port_sched_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [3:0]              req_valid;
  logic [4*ADDR_WIDTH-1:0] req_addr;
  logic [4*DATA_WIDTH-1:0] req_data;
  logic [3:0]              req_ready;
  logic [ADDR_WIDTH-1:0]   waddr1;
  logic [DATA_WIDTH-1:0]   wdata1;
  logic                    we1;
  logic [ADDR_WIDTH-1:0]   waddr2;
  logic [DATA_WIDTH-1:0]   wdata2;
  logic                    we2;
  logic                    init_done;
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, waddr1, wdata1, we1, waddr2, wdata2, we2, init_done
  );
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, waddr1, wdata1, we1, waddr2, wdata2, we2, init_done
  );
endinterface

// File: rtl/rf_write_port_sched.sv
// rf_write_port_sched: round-robin 4-to-2 write-port scheduler with post-reset RAM init sweep
module rf_write_port_sched #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DATA_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic                   clk,
  input logic                   reset,
  rf_write_port_sched_if.slave  bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  init_done_q, init_done_d;
  logic                  we1_q, we1_d, we2_q, we2_d;
  logic [ADDR_WIDTH-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
  logic [ADDR_WIDTH-1:0] addr [4];
  logic [DATA_WIDTH-1:0] data [4];
  logic                  s1_v, s2_v;
  logic [1:0]            s1, s2, idx;
  logic                  run;
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign addr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // Scan from rr_ptr: first valid requester takes slot 1, next valid one at a different address takes slot 2
  always_comb begin
    s1_v = 1'b0;
    s2_v = 1'b0;
    s1   = '0;
    s2   = '0;
    idx  = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (bus.req_valid[idx] && !s1_v) begin
        s1_v = 1'b1;
        s1   = idx;
      end else if (bus.req_valid[idx] && !s2_v && addr[idx] != addr[s1]) begin
        s2_v = 1'b1;
        s2   = idx;
      end
    end
  end
  assign run           = state_q == RUN && !reset;
  assign bus.req_ready = run ? ((s1_v ? 4'b1 << s1 : 4'b0) | (s2_v ? 4'b1 << s2 : 4'b0)) : 4'b0;
  assign bus.we1       = we1_q;
  assign bus.waddr1    = waddr1_q;
  assign bus.wdata1    = wdata1_q;
  assign bus.we2       = we2_q;
  assign bus.waddr2    = waddr2_q;
  assign bus.wdata2    = wdata2_q;
  assign bus.init_done = init_done_q;
  // Next state: init sweep on port 1, then issue granted slots; write strobes last one cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    we1_d       = 1'b0;
    we2_d       = 1'b0;
    waddr1_d    = waddr1_q;
    wdata1_d    = wdata1_q;
    waddr2_d    = waddr2_q;
    wdata2_d    = wdata2_q;
    if (state_q == INIT) begin
      we1_d       = 1'b1;
      waddr1_d    = cnt_q;
      wdata1_d    = INIT_VAL;
      cnt_d       = cnt_q + 1'b1;
      state_d     = cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1) ? RUN : INIT;
      init_done_d = cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1);
    end else begin
      we1_d    = s1_v;
      waddr1_d = s1_v ? addr[s1] : waddr1_q;
      wdata1_d = s1_v ? data[s1] : wdata1_q;
      we2_d    = s2_v;
      waddr2_d = s2_v ? addr[s2] : waddr2_q;
      wdata2_d = s2_v ? data[s2] : wdata2_q;
      rr_ptr_d = s1_v ? (s2_v ? s2 : s1) + 2'd1 : rr_ptr_q;
    end
  end
  // State register; reset drops pending work and restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      we1_q       <= 1'b0;
      we2_q       <= 1'b0;
      waddr1_q    <= '0;
      wdata1_q    <= '0;
      waddr2_q    <= '0;
      wdata2_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= init_done_d;
      we1_q       <= we1_d;
      we2_q       <= we2_d;
      waddr1_q    <= waddr1_d;
      wdata1_q    <= wdata1_d;
      waddr2_q    <= waddr2_d;
      wdata2_q    <= wdata2_d;
    end
  end
endmodule

// File: tb/tb_rf_write_port_sched.sv
// tb_rf_write_port_sched: directed checks of init sweep, round-robin pairing, same-address deferral and reset
module tb_rf_write_port_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] ram [32];
  rf_write_port_sched_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
  rf_write_port_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DATA_DEPTH(32), .INIT_VAL(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // Behavioural RAM fed by the two write ports
  always @(posedge clk) begin
    if (bus.we1) ram[bus.waddr1] <= bus.wdata1;
    if (bus.we2) ram[bus.waddr2] <= bus.wdata2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic [3:0] v, input logic [4:0] a0, a1, a2, a3,
                         input logic [31:0] d0, d1, d2, d3);
    bus.req_valid = v;
    bus.req_addr  = {a3, a2, a1, a0};
    bus.req_data  = {d3, d2, d1, d0};
    #1;
  endtask
  task automatic port1(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we1"}, bus.we1, we);
    chk({tag, "_waddr1"}, bus.waddr1, a);
    chk({tag, "_wdata1"}, bus.wdata1, d);
  endtask
  task automatic port2(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we2"}, bus.we2, we);
    if (we) chk({tag, "_waddr2"}, bus.waddr2, a);
    if (we) chk({tag, "_wdata2"}, bus.wdata2, d);
  endtask
  initial begin
    set_req(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    port1("rst", 1'b0, 5'd0, 32'h0);
    port2("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_waddr2", bus.waddr2, 32'h0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_ready", bus.req_ready, 4'b0000);
    set_req(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'h10, 32'h11, 32'h12, 32'h13);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      port1($sformatf("init%0d", i), 1'b1, 5'(i), 32'h0);
      chk("init_we2", bus.we2, 1'b0);
      chk("init_done", bus.init_done, i == 31);
      if (i < 31) chk("init_ready", bus.req_ready, 4'b0000);
    end
    chk("rr_a_ready", bus.req_ready, 4'b0011);
    step();
    port1("rr_a", 1'b1, 5'd1, 32'h10);
    port2("rr_a", 1'b1, 5'd2, 32'h11);
    set_req(4'b1100, 5'd1, 5'd2, 5'd3, 5'd4, 32'h10, 32'h11, 32'h12, 32'h13);
    chk("rr_b_ready", bus.req_ready, 4'b1100);
    step();
    port1("rr_b", 1'b1, 5'd3, 32'h12);
    port2("rr_b", 1'b1, 5'd4, 32'h13);
    set_req(4'b0000, 5'd1, 5'd2, 5'd3, 5'd4, 32'h10, 32'h11, 32'h12, 32'h13);
    chk("idle_ready", bus.req_ready, 4'b0000);
    step();
    port1("idle", 1'b0, 5'd3, 32'h12);
    chk("idle_we2", bus.we2, 1'b0);
    set_req(4'b0001, 5'd5, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    chk("single_ready", bus.req_ready, 4'b0001);
    step();
    port1("single", 1'b1, 5'd5, 32'hDEADBEEF);
    port2("single", 1'b0, 5'd0, 32'h0);
    set_req(4'b1000, 5'd0, 5'd0, 5'd0, 5'd20, 32'h0, 32'h0, 32'h0, 32'h33);
    chk("wrap_ready", bus.req_ready, 4'b1000);
    step();
    port1("wrap", 1'b1, 5'd20, 32'h33);
    port2("wrap", 1'b0, 5'd0, 32'h0);
    set_req(4'b0011, 5'd7, 5'd7, 5'd0, 5'd0, 32'hA, 32'hB, 32'h0, 32'h0);
    chk("same_a_ready", bus.req_ready, 4'b0001);
    step();
    port1("same_a", 1'b1, 5'd7, 32'hA);
    port2("same_a", 1'b0, 5'd0, 32'h0);
    set_req(4'b0010, 5'd7, 5'd7, 5'd0, 5'd0, 32'hA, 32'hB, 32'h0, 32'h0);
    chk("same_b_ready", bus.req_ready, 4'b0010);
    step();
    port1("same_b", 1'b1, 5'd7, 32'hB);
    port2("same_b", 1'b0, 5'd0, 32'h0);
    set_req(4'b1100, 5'd0, 5'd0, 5'd10, 5'd11, 32'h0, 32'h0, 32'h2A, 32'h3B);
    chk("pair23_ready", bus.req_ready, 4'b1100);
    step();
    chk("ram7", ram[7], 32'hB);
    port1("pair23", 1'b1, 5'd10, 32'h2A);
    port2("pair23", 1'b1, 5'd11, 32'h3B);
    set_req(4'b0111, 5'd7, 5'd7, 5'd9, 5'd0, 32'h70, 32'h71, 32'h90, 32'h0);
    chk("defer_a_ready", bus.req_ready, 4'b0101);
    step();
    port1("defer_a", 1'b1, 5'd7, 32'h70);
    port2("defer_a", 1'b1, 5'd9, 32'h90);
    set_req(4'b0010, 5'd7, 5'd7, 5'd9, 5'd0, 32'h70, 32'h71, 32'h90, 32'h0);
    chk("defer_b_ready", bus.req_ready, 4'b0010);
    step();
    port1("defer_b", 1'b1, 5'd7, 32'h71);
    port2("defer_b", 1'b0, 5'd0, 32'h0);
    set_req(4'b1111, 5'd12, 5'd13, 5'd14, 5'd15, 32'h1, 32'h2, 32'h3, 32'h4);
    reset = 1'b1;
    #1;
    chk("midrst_ready", bus.req_ready, 4'b0000);
    step();
    port1("midrst", 1'b0, 5'd0, 32'h0);
    port2("midrst", 1'b0, 5'd0, 32'h0);
    chk("midrst_init_done", bus.init_done, 1'b0);
    reset = 1'b0;
    #1;
    chk("resweep_ready", bus.req_ready, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      step();
      port1($sformatf("resweep%0d", i), 1'b1, 5'(i), 32'h0);
      chk("resweep_done", bus.init_done, i == 31);
      if (i < 31) chk("resweep_ready", bus.req_ready, 4'b0000);
    end
    chk("resweep_rr_ready", bus.req_ready, 4'b0011);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
